tx_ethernet: RTL and testbench

TX_ETHERNET -- requirements
Module: tx_ethernet

---
 rtl/tx_ethernet.sv | 236 +++++++++++++++++++++++
 tb/tb_tx_ethernet.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ethernet.sv
// tx_ethernet: MII Ethernet transmitter adding preamble/SFD, zero padding, CRC-32 FCS and inter-frame gap.
// Latency: first preamble nibble appears on the first Tx_clk rising edge after start_tx (plus 3 clk of sync).
// Backpressure: upstream is paced by byte_ack pulses; start_tx is ignored while busy.
//
// Ports: clk/reset      system clock (>= 4x Tx_clk), async active-high reset
//        Tx_clk         MII transmit clock from the PHY, sampled through a synchronizer
//        start_tx       request; tx_byte/tx_last must already hold the first byte
//        tx_byte/tx_last byte stream (destination address first), last-byte marker
//        byte_ack       tx_byte/tx_last captured, present the next byte from the following clk
//        busy/tx_done   frame in progress incl. IFG / pulse after the last FCS nibble
//        Tx_EN/Tx_data  MII transmit enable and nibble, registered in clk
module tx_ethernet #(
   parameter int MIN_LEN = 60,
   parameter int IFG_NIB = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Tx_clk,
   input  logic       start_tx,
   input  logic [7:0] tx_byte,
   input  logic       tx_last,
   output logic       byte_ack,
   output logic       busy,
   output logic       tx_done,
   output logic       Tx_EN,
   output logic [3:0] Tx_data
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      PREAMBLE = 4'd1,
      SFD      = 4'd2,
      DATA_LO  = 4'd3,
      DATA_HI  = 4'd4,
      PAD_LO   = 4'd5,
      PAD_HI   = 4'd6,
      FCS      = 4'd7,
      IFG      = 4'd8
   } state_t;

   localparam logic [31:0] CRC_POLY = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
   localparam logic [10:0] MIN_CNT  = 11'(MIN_LEN);
   localparam logic [15:0] IFG_LAST = 16'(IFG_NIB - 1);

   logic        tx_sync1, tx_sync2, tx_hist, tx_edge, edge_d;
   state_t      state_q, state_nxt;
   logic [7:0]  byte_q, byte_nxt;
   logic        last_q, last_nxt;
   logic        sent_last_q, sent_last_nxt;
   logic [15:0] cnt_q, cnt_nxt;
   logic [10:0] byte_cnt_q, byte_cnt_nxt;
   logic [31:0] crc_q, crc_nxt;
   logic        en_nxt, busy_nxt, ack_nxt, done_nxt;
   logic [3:0]  data_nxt;
   logic [2:0]  fcs_idx;

   // Reflected CRC-32, one nibble processed LSB first.
   function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
      logic [31:0] r;
      r = c ^ {28'd0, d};
      for (int i = 0; i < 4; i++) begin
         r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      end
      return r;
   endfunction

   function automatic logic [10:0] cnt_inc(input logic [10:0] c);
      return (c == 11'h7FF) ? c : c + 11'd1;
   endfunction

   // One clk pulse per Tx_clk rising edge.
   assign tx_edge = tx_sync2 & ~tx_hist;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_sync1    <= 1'b0;
         tx_sync2    <= 1'b0;
         tx_hist     <= 1'b0;
         edge_d      <= 1'b0;
         state_q     <= IDLE;
         byte_q      <= 8'd0;
         last_q      <= 1'b0;
         sent_last_q <= 1'b0;
         cnt_q       <= 16'd0;
         byte_cnt_q  <= 11'd0;
         crc_q       <= CRC_INIT;
         Tx_EN       <= 1'b0;
         Tx_data     <= 4'd0;
         busy        <= 1'b0;
         byte_ack    <= 1'b0;
         tx_done     <= 1'b0;
      end else begin
         tx_sync1    <= Tx_clk;
         tx_sync2    <= tx_sync1;
         tx_hist     <= tx_sync2;
         edge_d      <= tx_edge;
         state_q     <= state_nxt;
         byte_q      <= byte_nxt;
         last_q      <= last_nxt;
         sent_last_q <= sent_last_nxt;
         cnt_q       <= cnt_nxt;
         byte_cnt_q  <= byte_cnt_nxt;
         crc_q       <= crc_nxt;
         Tx_EN       <= en_nxt;
         Tx_data     <= data_nxt;
         busy        <= busy_nxt;
         byte_ack    <= ack_nxt;
         tx_done     <= done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state_q;
      byte_nxt      = byte_q;
      last_nxt      = last_q;
      sent_last_nxt = sent_last_q;
      cnt_nxt       = cnt_q;
      byte_cnt_nxt  = byte_cnt_q;
      crc_nxt       = crc_q;
      en_nxt        = Tx_EN;
      data_nxt      = Tx_data;
      busy_nxt      = busy;
      ack_nxt       = 1'b0;
      done_nxt      = 1'b0;
      fcs_idx       = cnt_q[2:0] + 3'd1;

      case (state_q)
         IDLE: begin
            // busy while still in IDLE means a request is waiting for its first Tx_clk edge
            if (!busy) begin
               if (start_tx) begin
                  byte_nxt     = tx_byte;
                  last_nxt     = tx_last;
                  ack_nxt      = 1'b1;
                  busy_nxt     = 1'b1;
                  byte_cnt_nxt = 11'd0;
               end
            end else if (tx_edge) begin
               state_nxt = PREAMBLE;
               en_nxt    = 1'b1;
               data_nxt  = 4'h5;
               cnt_nxt   = 16'd1;
            end
         end
         PREAMBLE: if (tx_edge) begin
            if (cnt_q < 16'd15) begin
               data_nxt = 4'h5;
               cnt_nxt  = cnt_q + 16'd1;
            end else begin
               state_nxt = SFD;
               data_nxt  = 4'hD;
               crc_nxt   = CRC_INIT;
            end
         end
         SFD: if (tx_edge) begin
            state_nxt = DATA_LO;
            data_nxt  = byte_q[3:0];
            crc_nxt   = crc_nib(crc_q, byte_q[3:0]);
         end
         DATA_LO: if (tx_edge) begin
            // High nibble goes out from the old byte while the next byte is captured.
            state_nxt     = DATA_HI;
            data_nxt      = byte_q[7:4];
            crc_nxt       = crc_nib(crc_q, byte_q[7:4]);
            byte_cnt_nxt  = cnt_inc(byte_cnt_q);
            sent_last_nxt = last_q;
            if (!last_q) begin
               byte_nxt = tx_byte;
               last_nxt = tx_last;
               ack_nxt  = 1'b1;
            end
         end
         DATA_HI, PAD_HI: if (tx_edge) begin
            if (state_q == DATA_HI && !sent_last_q) begin
               state_nxt = DATA_LO;
               data_nxt  = byte_q[3:0];
               crc_nxt   = crc_nib(crc_q, byte_q[3:0]);
            end else if (byte_cnt_q < MIN_CNT) begin
               state_nxt = PAD_LO;
               data_nxt  = 4'h0;
               crc_nxt   = crc_nib(crc_q, 4'h0);
            end else begin
               state_nxt = FCS;
               data_nxt  = ~crc_q[3:0];
               cnt_nxt   = 16'd0;
            end
         end
         PAD_LO: if (tx_edge) begin
            state_nxt    = PAD_HI;
            data_nxt     = 4'h0;
            crc_nxt      = crc_nib(crc_q, 4'h0);
            byte_cnt_nxt = cnt_inc(byte_cnt_q);
         end
         FCS: begin
            // edge_d marks the first clk a freshly driven nibble is visible on Tx_data.
            if (edge_d && cnt_q[2:0] == 3'd7) begin
               done_nxt = 1'b1;
            end
            if (tx_edge) begin
               if (cnt_q[2:0] == 3'd7) begin
                  state_nxt = IFG;
                  en_nxt    = 1'b0;
                  data_nxt  = 4'h0;
                  cnt_nxt   = 16'd1;
               end else begin
                  cnt_nxt  = cnt_q + 16'd1;
                  data_nxt = ~crc_q[{fcs_idx, 2'b00} +: 4];
               end
            end
         end
         IFG: if (tx_edge) begin
            if (cnt_q >= IFG_LAST) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               cnt_nxt   = 16'd0;
            end else begin
               cnt_nxt = cnt_q + 16'd1;
            end
         end
         default: begin
            state_nxt     = IDLE;
            byte_nxt      = 8'd0;
            last_nxt      = 1'b0;
            sent_last_nxt = 1'b0;
            cnt_nxt       = 16'd0;
            byte_cnt_nxt  = 11'd0;
            crc_nxt       = CRC_INIT;
            en_nxt        = 1'b0;
            data_nxt      = 4'd0;
            busy_nxt      = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_tx_ethernet.sv
// tb_tx_ethernet: scoreboard bench for tx_ethernet (default instance plus a MIN_LEN=0 instance).
// Expected MII nibbles are queued when a frame is set up and popped on each Tx_clk falling edge.
// Byte feeding follows byte_ack; per-frame checks cover acks, tx_done, nibble count and gaps.
module tb_tx_ethernet;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       Tx_clk = 1'b0;
   logic       tx_run = 1'b1;
   logic       start_tx = 1'b0;
   logic [7:0] tx_byte = 8'd0;
   logic       tx_last = 1'b0;
   logic       sel = 1'b0;

   logic       start_a, ack_a, busy_a, done_a, en_a;
   logic       start_b, ack_b, busy_b, done_b, en_b;
   logic [3:0] data_a, data_b;
   logic       o_ack, o_busy, o_done, o_en;
   logic [3:0] o_data;

   assign start_a = start_tx & ~sel;
   assign start_b = start_tx & sel;
   assign o_ack   = sel ? ack_b  : ack_a;
   assign o_busy  = sel ? busy_b : busy_a;
   assign o_done  = sel ? done_b : done_a;
   assign o_en    = sel ? en_b   : en_a;
   assign o_data  = sel ? data_b : data_a;

   tx_ethernet u_dut (
      .clk(clk), .reset(reset), .Tx_clk(Tx_clk), .start_tx(start_a),
      .tx_byte(tx_byte), .tx_last(tx_last), .byte_ack(ack_a), .busy(busy_a),
      .tx_done(done_a), .Tx_EN(en_a), .Tx_data(data_a)
   );

   tx_ethernet #(.MIN_LEN(0)) u_dut_nopad (
      .clk(clk), .reset(reset), .Tx_clk(Tx_clk), .start_tx(start_b),
      .tx_byte(tx_byte), .tx_last(tx_last), .byte_ack(ack_b), .busy(busy_b),
      .tx_done(done_b), .Tx_EN(en_b), .Tx_data(data_b)
   );

   always #5 clk = ~clk;

   // Tx_clk period 120 ns; when stopped it parks low.
   initial begin
      #2;
      forever begin
         #60;
         if (tx_run || Tx_clk) Tx_clk = ~Tx_clk;
      end
   end

   int checks = 0;
   int passes = 0;
   int ack_cnt = 0;
   int done_cnt = 0;
   int en_cnt = 0;
   int gap_run = 0;
   int last_gap = -1;
   logic       done_en;
   logic [3:0] done_dat;
   logic [3:0] exp_last;
   logic [3:0] exp_n;
   logic [3:0] exp_q [$];
   logic [3:0] rx_nib [$];
   logic [7:0] frm [$];
   logic [3:0] fcs_ref [0:7] = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};

   always @(negedge clk) begin
      if (o_ack) ack_cnt++;
      if (o_done) begin
         done_cnt++;
         done_en  = o_en;
         done_dat = o_data;
      end
   end

   always @(negedge Tx_clk) begin
      if (o_en) begin
         en_cnt++;
         rx_nib.push_back(o_data);
         if (gap_run != 0) last_gap = gap_run;
         gap_run = 0;
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_nibble: got %h, none expected", o_data);
         end else begin
            exp_n = exp_q.pop_front();
            if (o_data !== exp_n) $display("FAIL nibble: got %h, expected %h", o_data, exp_n);
            else passes++;
         end
      end else begin
         gap_run++;
         checks++;
         if (o_data !== 4'h0) $display("FAIL idle_data: got %h, expected 0", o_data);
         else passes++;
      end
   end

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
         else r = r >> 1;
      end
      return r;
   endfunction

   task automatic set_frame(input int n, input int seed);
      frm.delete();
      for (int i = 0; i < n; i++) frm.push_back(8'((i * 37 + seed) & 255));
   endtask

   task automatic expect_frame(input bit model_fcs, input int min_len);
      logic [7:0]  b [$];
      logic [31:0] c;
      exp_q.delete();
      repeat (15) exp_q.push_back(4'h5);
      exp_q.push_back(4'hD);
      b = frm;
      while (b.size() < min_len) b.push_back(8'h00);
      c = 32'hFFFFFFFF;
      foreach (b[i]) begin
         exp_q.push_back(b[i][3:0]);
         exp_q.push_back(b[i][7:4]);
         c = crc_upd(c, b[i]);
      end
      c = ~c;
      for (int k = 0; k < 8; k++) begin
         if (model_fcs) exp_q.push_back(c[4*k +: 4]);
         else exp_q.push_back(fcs_ref[k]);
      end
      exp_last = exp_q[exp_q.size() - 1];
   endtask

   task automatic drive_frame(input int abort_at, input int stall_at, input bit spam, input int total);
      int idx, ack_base, done_base, en_base;
      bit stalled, frozen, timed_out;
      logic en_hold;
      logic [3:0] dat_hold;
      ack_base = ack_cnt; done_base = done_cnt; en_base = en_cnt;
      idx = 0; stalled = 0; timed_out = 1;
      tx_byte = frm[0];
      tx_last = (frm.size() == 1);
      start_tx = 1'b1;
      @(negedge clk);
      start_tx = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (o_ack) begin
            idx++;
            if (idx < frm.size()) begin
               tx_byte = frm[idx];
               tx_last = (idx == frm.size() - 1);
            end
         end
         if (!o_busy) begin
            timed_out = 0;
            break;
         end
         start_tx = spam && (cyc % 13 == 5);
         if (abort_at > 0 && en_cnt - en_base >= abort_at) begin
            start_tx = 1'b0;
            reset = 1'b1;
            exp_q.delete();
            #1;
            checks++;
            if (o_en !== 1'b0 || o_busy !== 1'b0)
               $display("FAIL abort_outputs: Tx_EN=%b busy=%b, expected 0 0", o_en, o_busy);
            else passes++;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            repeat (40) @(negedge clk);
            checks++;
            if (done_cnt != done_base) $display("FAIL abort_no_done: tx_done pulses %0d, expected 0", done_cnt - done_base);
            else passes++;
            return;
         end
         if (stall_at > 0 && !stalled && en_cnt - en_base >= stall_at) begin
            stalled = 1;
            tx_run = 1'b0;
            repeat (20) @(negedge clk);
            en_hold = o_en; dat_hold = o_data; frozen = 1;
            repeat (100) begin
               @(negedge clk);
               if (o_en !== en_hold || o_data !== dat_hold || o_ack || o_done) frozen = 0;
            end
            checks++;
            if (!frozen || en_hold !== 1'b1 || dat_hold !== 4'h5)
               $display("FAIL stall_frozen: frozen=%0d Tx_EN=%b Tx_data=%h, expected 1 1 5", frozen, en_hold, dat_hold);
            else passes++;
            tx_run = 1'b1;
         end
         @(negedge clk);
      end
      start_tx = 1'b0;
      checks++;
      if (timed_out) $display("FAIL frame_timeout: busy still %b after cycle budget, expected 0", o_busy);
      else passes++;
      checks++;
      if (ack_cnt - ack_base != frm.size()) $display("FAIL byte_ack_count: got %0d, expected %0d", ack_cnt - ack_base, frm.size());
      else passes++;
      checks++;
      if (done_cnt - done_base != 1) $display("FAIL tx_done_count: got %0d, expected 1", done_cnt - done_base);
      else passes++;
      checks++;
      if (en_cnt - en_base != total) $display("FAIL tx_en_nibbles: got %0d, expected %0d", en_cnt - en_base, total);
      else passes++;
      checks++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d nibbles left, expected 0", exp_q.size());
      else passes++;
      checks++;
      if (done_en !== 1'b1 || done_dat !== exp_last)
         $display("FAIL tx_done_timing: Tx_EN=%b Tx_data=%h at tx_done, expected 1 %h", done_en, done_dat, exp_last);
      else passes++;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({en_a, data_a, busy_a, ack_a, done_a} !== 8'd0)
         $display("FAIL reset_outputs_a: got %b, expected 0", {en_a, data_a, busy_a, ack_a, done_a});
      else passes++;
      checks++;
      if ({en_b, data_b, busy_b, ack_b, done_b} !== 8'd0)
         $display("FAIL reset_outputs_b: got %b, expected 0", {en_b, data_b, busy_b, ack_b, done_b});
      else passes++;
      reset = 1'b0;
      repeat (30) @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || en_a !== 1'b0) $display("FAIL post_reset_idle: busy=%b Tx_EN=%b, expected 0 0", busy_a, en_a);
      else passes++;
   endtask

   task automatic test_crc_vector;
      sel = 1'b1;
      frm.delete();
      for (int i = 0; i < 9; i++) frm.push_back(8'(8'h31 + i));
      expect_frame(1'b0, 0);
      drive_frame(0, 0, 1'b0, 42);
   endtask

   task automatic test_padding;
      logic [31:0] c;
      int nbytes;
      sel = 1'b0;
      set_frame(14, 3);
      expect_frame(1'b1, 60);
      rx_nib.delete();
      drive_frame(0, 0, 1'b0, 144);
      c = 32'hFFFFFFFF;
      nbytes = 0;
      for (int j = 16; j + 1 < rx_nib.size(); j += 2) begin
         c = crc_upd(c, {rx_nib[j + 1], rx_nib[j]});
         nbytes++;
      end
      checks++;
      if (nbytes != 64) $display("FAIL pad_length: got %0d bytes incl FCS, expected 64", nbytes);
      else passes++;
      checks++;
      if (c !== 32'hDEBB20E3) $display("FAIL crc_residue: got %h, expected deb b20e3", c);
      else passes++;
   endtask

   task automatic test_ignore_start;
      int ack_base;
      sel = 1'b1;
      set_frame(6, 90);
      expect_frame(1'b1, 0);
      drive_frame(0, 0, 1'b1, 36);
      ack_base = ack_cnt;
      repeat (30) @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || ack_cnt != ack_base)
         $display("FAIL start_ignored: busy=%b extra_acks=%0d, expected 0 0", o_busy, ack_cnt - ack_base);
      else passes++;
   endtask

   task automatic test_back_to_back;
      sel = 1'b0;
      set_frame(60, 11);
      expect_frame(1'b1, 60);
      drive_frame(0, 0, 1'b0, 144);
      set_frame(61, 200);
      expect_frame(1'b1, 60);
      drive_frame(0, 0, 1'b0, 146);
      checks++;
      if (last_gap != 24) $display("FAIL ifg_gap: got %0d Tx_clk periods, expected 24", last_gap);
      else passes++;
   endtask

   task automatic test_reset_mid_frame;
      sel = 1'b0;
      set_frame(20, 55);
      expect_frame(1'b1, 60);
      drive_frame(30, 0, 1'b0, 0);
      set_frame(14, 77);
      expect_frame(1'b1, 60);
      drive_frame(0, 0, 1'b0, 144);
   endtask

   task automatic test_tx_clk_stall;
      sel = 1'b0;
      set_frame(14, 129);
      expect_frame(1'b1, 60);
      drive_frame(0, 5, 1'b0, 144);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_crc_vector();
      test_padding();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_frame();
      test_tx_clk_stall();
      repeat (10) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
